// File: rtl/registros_serializer_if.sv
// Parallel write port, start request and serial framing outputs of the register-bank serializer.
// The master side loads the bank and requests frames; the slave side shifts the frames out.
interface registros_serializer_if #(
    parameter int unsigned NREG  = 8,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             busy;
    logic             done;
    logic             sdata;
    logic             svalid;
    logic             sfirst;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  busy, done, sdata, svalid, sfirst
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output busy, done, sdata, svalid, sfirst
    );
endinterface

// File: rtl/registros_serializer.sv
// Register-bank serializer: snapshots an NREG x WIDTH bank on start and shifts it out MSB first.
// Optional feature: define REGISTROS_PARITY_EN to append an even-parity bit after each register.
module registros_serializer #(
    parameter int unsigned NREG  = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    registros_serializer_if.slave  bus
);
    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BitFirst = BW'(WIDTH - 1);
    localparam logic [AW-1:0] RegLast  = AW'(NREG - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bank_q [NREG];
    logic [WIDTH-1:0] snap_q [NREG];
    logic [AW-1:0]    reg_q, reg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] cur_word;
    logic             cur_bit;
    logic             last_bit;
    logic             shifting;
`ifdef REGISTROS_PARITY_EN
    logic             par_q, par_d;
`endif

    // Live bank accepts writes in every state; the frame reads only the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            bank_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                snap_q[i] <= '0;
            end
        end else if (state_q == StIdle && bus.start) begin
            snap_q <= bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            reg_q   <= '0;
            bit_q   <= BitFirst;
`ifdef REGISTROS_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            bit_q   <= bit_d;
`ifdef REGISTROS_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        cur_word = snap_q[reg_q];
`ifdef REGISTROS_PARITY_EN
        cur_bit  = par_q ? ^cur_word : cur_word[bit_q];
        last_bit = par_q && (reg_q == RegLast);
`else
        cur_bit  = cur_word[bit_q];
        last_bit = (bit_q == '0) && (reg_q == RegLast);
`endif
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        bit_d   = bit_q;
`ifdef REGISTROS_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last_bit) begin
                    // Counters return to their initial values as the frame closes.
                    state_d = StDone;
                    reg_d   = '0;
                    bit_d   = BitFirst;
`ifdef REGISTROS_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else begin
`ifdef REGISTROS_PARITY_EN
                    if (par_q) begin
                        par_d = 1'b0;
                        bit_d = BitFirst;
                        reg_d = reg_q + AW'(1);
                    end else if (bit_q == '0) begin
                        par_d = 1'b1;
                    end else begin
                        bit_d = bit_q - BW'(1);
                    end
`else
                    if (bit_q == '0) begin
                        bit_d = BitFirst;
                        reg_d = reg_q + AW'(1);
                    end else begin
                        bit_d = bit_q - BW'(1);
                    end
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        shifting   = (state_q == StShift);
        bus.busy   = shifting;
        bus.svalid = shifting;
        bus.sdata  = shifting && cur_bit;
        bus.done   = (state_q == StDone);
`ifdef REGISTROS_PARITY_EN
        bus.sfirst = shifting && (reg_q == '0) && (bit_q == BitFirst) && !par_q;
`else
        bus.sfirst = shifting && (reg_q == '0) && (bit_q == BitFirst);
`endif
    end
endmodule

// File: tb/tb_registros_serializer.sv
// Self-checking bench for registros_serializer: a bank/frame model drives randomized scenarios.
// Expected frames are built from a model bank with plain index arithmetic.
module tb_registros_serializer;
    localparam int unsigned NREG  = 8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = $clog2(NREG);
`ifdef REGISTROS_PARITY_EN
    localparam int SLOT = WIDTH + 1;
`else
    localparam int SLOT = WIDTH;
`endif
    localparam int L = NREG * SLOT;

    typedef logic [WIDTH-1:0] bank_t [NREG];

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    errors = 0;
    bank_t model_bank;

    registros_serializer_if #(.NREG(NREG), .WIDTH(WIDTH)) bus ();

    registros_serializer #(.NREG(NREG), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input bank_t snap, input int k);
        int r;
        int p;
        r = k / SLOT;
        p = k % SLOT;
        if (p < WIDTH) return snap[r][WIDTH-1-p];
        return ^snap[r];
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if (bus.svalid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.sdata !== 1'b0 || bus.sfirst !== 1'b0) begin
            errors++;
            $display("FAIL %s: svalid=%b busy=%b done=%b sdata=%b sfirst=%b, required all 0",
                     name, bus.svalid, bus.busy, bus.done, bus.sdata, bus.sfirst);
        end
    endtask

    // Called on the first-bit cycle; checks nbits frame bits and, for a full frame, the DONE cycle.
    task automatic check_frame(input bank_t snap, input string name, input bit hold_start,
                               input int mid_k, input logic [AW-1:0] mid_a,
                               input logic [WIDTH-1:0] mid_d, input bit mid_start,
                               input int nbits);
        for (int k = 0; k < nbits; k++) begin
            checks++;
            if (bus.svalid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                bus.sfirst !== (k == 0) || bus.sdata !== exp_bit(snap, k)) begin
                errors++;
                $display("FAIL %s bit %0d: svalid=%b busy=%b done=%b sfirst=%b sdata=%b, required 1 1 0 %b %b",
                         name, k, bus.svalid, bus.busy, bus.done, bus.sfirst, bus.sdata,
                         (k == 0), exp_bit(snap, k));
            end
            bus.start = hold_start || (k == mid_k && mid_start);
            if (k == mid_k) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = mid_a;
                bus.wr_data = mid_d;
                model_bank[mid_a] = mid_d;
            end
            tick();
            bus.wr_en = 1'b0;
            bus.start = hold_start;
        end
        if (nbits == L) begin
            checks++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.svalid !== 1'b0 ||
                bus.sdata !== 1'b0) begin
                errors++;
                $display("FAIL %s done: done=%b busy=%b svalid=%b sdata=%b, required 1 0 0 0",
                         name, bus.done, bus.busy, bus.svalid, bus.sdata);
            end
            tick();
        end
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        model_bank[a] = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic send_frame(input string name);
        bank_t snap;
        snap = model_bank;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_frame(snap, name, 1'b0, -1, '0, '0, 1'b0, L);
        check_idle({name, "_after"});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_idle("reset");
        end
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < NREG; i++) model_bank[i] = '0;
        tick();
        check_idle("post_reset");
        send_frame("reset_zero_frame");
    endtask

    task automatic test_basic_frame();
        for (int i = 0; i < NREG; i++) write_reg(AW'(i), WIDTH'(8'hA0 + i));
        send_frame("basic_a0");
    endtask

    task automatic test_write_during_frame();
        bank_t snap;
        snap = model_bank;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_frame(snap, "write_during", 1'b0, 10, '0, 8'hFF, 1'b1, L);
        check_idle("no_restart");
        send_frame("after_ff");
    endtask

    task automatic test_same_edge();
        bank_t snap;
        snap = model_bank;
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = 8'h3C;
        model_bank[0] = 8'h3C;
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check_frame(snap, "same_edge_old", 1'b0, -1, '0, '0, 1'b0, L);
        check_idle("same_edge_after");
        send_frame("same_edge_new");
    endtask

    task automatic test_reset_mid_frame();
        bank_t snap;
        snap = model_bank;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_frame(snap, "pre_abort", 1'b0, -1, '0, '0, 1'b0, 20);
        rst = 1'b1;
        tick();
        check_idle("abort");
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) model_bank[i] = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("abort_no_done");
        end
        send_frame("abort_zero_frame");
    endtask

    task automatic test_back_to_back();
        bank_t snap;
        for (int i = 0; i < NREG; i++) write_reg(AW'(i), WIDTH'($urandom));
        snap = model_bank;
        bus.start = 1'b1;
        tick();
        check_frame(snap, "b2b_first", 1'b1, -1, '0, '0, 1'b0, L);
        check_idle("b2b_gap");
        tick();
        bus.start = 1'b0;
        check_frame(model_bank, "b2b_second", 1'b0, -1, '0, '0, 1'b0, L);
        check_idle("b2b_after");
    endtask

    task automatic test_random();
        bank_t snap;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < NREG; i++) write_reg(AW'($urandom_range(NREG - 1)), WIDTH'($urandom));
            snap = model_bank;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check_frame(snap, "random", 1'b0, $urandom_range(L - 1), AW'($urandom_range(NREG - 1)),
                        WIDTH'($urandom), 1'($urandom_range(1)), L);
            check_idle("random_after");
            send_frame("random_followup");
        end
    endtask

`ifdef REGISTROS_PARITY_EN
    task automatic test_parity();
        for (int i = 0; i < NREG; i++) write_reg(AW'(i), (i == 0) ? 8'h07 : 8'h00);
        send_frame("parity_07");
    endtask
`endif

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        test_reset();
        test_basic_frame();
        test_write_during_frame();
        test_same_edge();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
`ifdef REGISTROS_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
